// File: rtl/cla_lfsr_tester.sv
// cla_lfsr_tester: LFSR-driven BIST stage that drives a 16-bit CLA add/sub and
// checks its sum/cout against a behavioural result, counting vectors and errors.
module cla_lfsr_tester #(
   parameter logic [15:0] DEF_SEED = 16'hACE1,
   parameter logic [15:0] POLY     = 16'hB400
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [15:0] seed,
   input  logic [15:0] num_vec,
   output logic [15:0] ain,
   output logic [15:0] bin,
   output logic        cin,
   output logic        sub,
   input  logic [15:0] sum_in,
   input  logic        cout_in,
   output logic        busy,
   output logic        done,
   output logic        pass,
   output logic [15:0] vec_cnt,
   output logic [15:0] err_cnt
);
   typedef enum logic [2:0] {IDLE, GEN_A, GEN_B, WAIT, CHECK, DONE} state_t;
   state_t state, state_nxt;
   logic [15:0] lfsr, lfsr_step, num_lat;
   logic [16:0] exp_val;
   logic last, mismatch;
   always_comb begin
      lfsr_step = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? POLY : 16'h0);
      exp_val   = sub ? {1'b0, ain} + {1'b0, ~bin} + 17'd1
                      : {1'b0, ain} + {1'b0, bin} + {16'd0, cin};
      mismatch  = {cout_in, sum_in} != exp_val;
      last      = (vec_cnt + 16'd1) == num_lat;
   end
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE, DONE: if (start) state_nxt = (num_vec != 16'h0) ? GEN_A : DONE;
         GEN_A:      state_nxt = GEN_B;
         GEN_B:      state_nxt = WAIT;
         WAIT:       state_nxt = CHECK;
         CHECK:      state_nxt = last ? DONE : GEN_A;
         default:    state_nxt = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lfsr    <= DEF_SEED;
         num_lat <= 16'h0;
         ain     <= 16'h0;
         bin     <= 16'h0;
         cin     <= 1'b0;
         sub     <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
         vec_cnt <= 16'h0;
         err_cnt <= 16'h0;
      end else begin
         case (state)
            IDLE, DONE: if (start) begin
               lfsr    <= (seed == 16'h0) ? DEF_SEED : seed;
               num_lat <= num_vec;
               vec_cnt <= 16'h0;
               err_cnt <= 16'h0;
               busy    <= num_vec != 16'h0;
               done    <= num_vec == 16'h0;
            end
            GEN_A: begin
               ain  <= lfsr;
               lfsr <= lfsr_step;
            end
            GEN_B: begin
               bin  <= lfsr;
               sub  <= lfsr[15];
               cin  <= lfsr[14];
               lfsr <= lfsr_step;
            end
            CHECK: begin
               vec_cnt <= vec_cnt + 16'd1;
               if (mismatch && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
               if (last) begin
                  busy <= 1'b0;
                  done <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end
   assign pass = done & (err_cnt == 16'h0);
endmodule

// File: tb/tb_cla_lfsr_tester.sv
// tb_cla_lfsr_tester: drives cla_lfsr_tester with a behavioural CLA (optionally
// faulted) and checks the operand stream and final counts against an LFSR model.
module tb_cla_lfsr_tester;
   logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
   logic [15:0] seed = 16'h0, num_vec = 16'h0;
   logic [15:0] ain, bin, sum_in, vec_cnt, err_cnt;
   logic cin, sub, cout_in, busy, done, pass;
   int fault = 0;
   logic [16:0] cla_r;

   always #5 clk = ~clk;

   // fault 1: sum bit 0 stuck at 0; fault 2: add path ignores cin
   always_comb begin
      cla_r = sub ? {1'b0, ain} + {1'b0, ~bin} + 17'd1
                  : {1'b0, ain} + {1'b0, bin} + {16'd0, (fault == 2) ? 1'b0 : cin};
      if (fault == 1) cla_r[0] = 1'b0;
   end
   assign {cout_in, sum_in} = cla_r;

   cla_lfsr_tester dut (
      .clk(clk), .rst_n(rst_n), .start(start), .seed(seed), .num_vec(num_vec),
      .ain(ain), .bin(bin), .cin(cin), .sub(sub), .sum_in(sum_in), .cout_in(cout_in),
      .busy(busy), .done(done), .pass(pass), .vec_cnt(vec_cnt), .err_cnt(err_cnt)
   );

   int n_chk = 0, n_fail = 0;
   int cov_a0 = 0, cov_a1 = 0, cov_s = 0;
   logic [33:0] sb[$];

   typedef struct {
      logic [15:0] seed;
      logic [15:0] num;
      int          fault;
      logic        chk_first;
      logic [33:0] first;
      logic        glitch;
   } vec_t;
   vec_t tbl[6];
   vec_t t5;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] step(input logic [15:0] x);
      return (x >> 1) ^ (x[0] ? 16'hB400 : 16'h0);
   endfunction

   task automatic run(input vec_t v);
      logic [15:0] l;
      logic [33:0] e;
      logic [16:0] r;
      int exp_err = 0;
      sb.delete();
      fault = v.fault;
      l = (v.seed == 16'h0) ? 16'hACE1 : v.seed;
      for (int k = 0; k < int'(v.num); k++) begin
         e[33:18] = l;
         l = step(l);
         e[17:2] = l;
         e[1] = l[15];
         e[0] = l[14];
         l = step(l);
         r = e[1] ? {1'b0, e[33:18]} + {1'b0, ~e[17:2]} + 17'd1
                  : {1'b0, e[33:18]} + {1'b0, e[17:2]} + {16'd0, e[0]};
         if ((v.fault == 1 && r[0]) || (v.fault == 2 && !e[1] && e[0])) exp_err++;
         sb.push_back(e);
      end
      seed = v.seed;
      num_vec = v.num;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      check("busy_after_start", busy, 1);
      for (int k = 0; k < int'(v.num); k++) begin
         repeat (3) @(posedge clk);
         #1 e = sb.pop_front();
         check("operands", {ain, bin, sub, cin}, e);
         if (k == 0 && v.chk_first) check("first_vec", {ain, bin, sub, cin}, v.first);
         check("not_done", done, 0);
         if (sub) cov_s++;
         else if (cin) cov_a1++;
         else cov_a0++;
         if (v.glitch && k == 1) start = 1'b1;
         @(posedge clk);
         #1 start = 1'b0;
         check("vec_cnt", vec_cnt, 64'(k + 1));
      end
      check("done", done, 1);
      check("busy_end", busy, 0);
      check("err_cnt", err_cnt, 64'(exp_err));
      check("pass", pass, exp_err == 0);
   endtask

   initial begin
      tbl[0] = '{16'h0001, 16'd1,     0, 1'b1, {16'h0001, 16'hB400, 1'b1, 1'b0}, 1'b0};
      tbl[1] = '{16'h0000, 16'd1,     0, 1'b1, {16'hACE1, 16'hE270, 1'b1, 1'b1}, 1'b0};
      tbl[2] = '{16'h1234, 16'd1000,  1, 1'b0, 34'h0, 1'b0};
      tbl[3] = '{16'h1234, 16'd1000,  0, 1'b0, 34'h0, 1'b0};
      tbl[4] = '{16'hBEEF, 16'd10000, 0, 1'b0, 34'h0, 1'b0};
      tbl[5] = '{16'h5A5A, 16'd300,   2, 1'b0, 34'h0, 1'b0};
      t5     = '{16'h0F0F, 16'd10,    0, 1'b0, 34'h0, 1'b1};
      #1 check("reset_outputs", {ain, bin, cin, sub, busy, done, pass, vec_cnt, err_cnt}, 0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk);
      #1;
      for (int i = 0; i < 6; i++) run(tbl[i]);
      check("cov_add_cin0", cov_a0 > 0, 1);
      check("cov_add_cin1", cov_a1 > 0, 1);
      check("cov_sub", cov_s > 0, 1);
      // zero-length run completes on the start edge without ever going busy
      num_vec = 16'd0;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      check("t4_done", done, 1);
      check("t4_pass", pass, 1);
      check("t4_busy", busy, 0);
      check("t4_vec_cnt", vec_cnt, 0);
      @(posedge clk);
      #1 check("t4_hold", {busy, done}, 2'b01);
      // asynchronous reset in the middle of the third vector
      fault = 0;
      seed = 16'h0F0F;
      num_vec = 16'd10;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (10) @(posedge clk);
      #1 rst_n = 1'b0;
      #2 check("t5_reset", {ain, bin, cin, sub, busy, done, pass, vec_cnt, err_cnt}, 0);
      @(negedge clk) rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1 check("t5_idle", {busy, done}, 0);
      run(t5);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
